axi4_lite_regfile_gen: RTL and testbench
========================================

// Module: axi4_lite_regfile_gen
// PURPOSE
//  Parametrised AXI4-Lite register-file slave: NUM_REGS registers of DATA_WIDTH bits.
//  Access type per register (RW / RO / W1C) is set by parameter masks.
//  Exposes a flat hardware-side interface: register values out, RO values in,
//  W1C set pulses in, per-register write strobes out, plus an aggregated interrupt.
//  Sits behind the AXI4-Lite interconnect as the generic control/status block for IP cores.
// PARAMETERS
//  ADDR_WIDTH  32            AXI address width.
//  DATA_WIDTH  32            AXI data width; 32 or 64 only. STRB_WIDTH = DATA_WIDTH/8.
//  NUM_REGS    16            Register count; power of 2, range 2..256.
//  RO_MASK     '0            [NUM_REGS-1:0]; bit i=1 -> reg i is read-only (value = hw_ro_data slice i).
//  W1C_MASK    '0            [NUM_REGS-1:0]; bit i=1 -> reg i is write-1-to-clear. Must not overlap RO_MASK.
//  RST_VAL     '0            DATA_WIDTH reset value applied to every RW register.
// PORTS
//  aclk          in   1                    Clock.
//  areset        in   1                    Asynchronous reset, active-high.
//  awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1   AW channel.
//  wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1   W channel.
//  bresp/bvalid/bready     out/out/in 2/1/1            B channel.
//  araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1   AR channel.
//  rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1   R channel.
//  reg_q         out  NUM_REGS*DATA_WIDTH  Current value of every register (slice i = reg i).
//  hw_ro_data    in   NUM_REGS*DATA_WIDTH  Source for RO registers; ignored for others.
//  hw_set        in   NUM_REGS*DATA_WIDTH  Per-bit set pulses for W1C registers; ignored for others.
//  wr_pulse      out  NUM_REGS             1-cycle strobe: reg i accepted a write with OKAY.
//  irq           out  1                    Registered OR of all bits of all W1C registers.
// BEHAVIOUR
//  Reset: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; wr_pulse=0; irq=0;
//   RW regs=RST_VAL; W1C regs=0. Any in-flight transaction is dropped; no B/R is issued for it.
//  Decode: byte offset = addr; index = addr[IDX_LSB +: log2(NUM_REGS)], IDX_LSB = log2(STRB_WIDTH).
//   In range iff addr >> (IDX_LSB+log2(NUM_REGS)) == 0; otherwise SLVERR, no register state changes.
//  Write FSM states: IDLE, GOT_AW, GOT_W, RESP.
//   IDLE: awready=wready=1. Both fire -> commit, go RESP. AW only -> GOT_AW. W only -> GOT_W.
//   GOT_AW: wready=1, awready=0; W fire -> commit, go RESP. GOT_W: mirror image.
//   Commit happens on the clock edge of the completing handshake; bvalid=1 on the next cycle.
//   RESP: awready=wready=0; hold bvalid/bresp until bready; then IDLE (no new accept that cycle).
//   Commit: RW -> byte-merge under wstrb; RO -> no change, bresp=OKAY; W1C -> clear bits where
//   wdata=1 in strobed bytes. wr_pulse[i]=1 for exactly one cycle, the cycle after commit, RW/W1C only.
//  Read FSM states: IDLE, RESP. arready=1 only in IDLE. rdata/rresp sampled at AR fire, rvalid next
//   cycle, held stable until rready. Out of range -> rdata=0, rresp=SLVERR. RO reads return hw_ro_data
//   as sampled at the AR fire edge.
//  Read and write are independent. Same-cycle AR fire and commit to the same register -> read returns the pre-write value.
//  W1C: hw_set applied every cycle; same-cycle hw_set bit and SW clear of that bit -> bit stays 1 (set wins).
//  irq: registered, 1-cycle latency from W1C register update.
//  Strobe with wstrb=0 -> legal no-op, OKAY, wr_pulse still asserted.
// STRUCTURE
//  axi_pkg: add RESP_OKAY/RESP_SLVERR (reuse), typedef enum reg_access_e {ACC_RW, ACC_RO, ACC_W1C}.
//  Add wr_state_e and rd_state_e enums to axi_pkg as well.
//  Sub-module axi4_lite_reg_cell: one register.
//   Inputs: access type, commit, wdata, wstrb, hw_set, hw_ro_data. Output: q.
//  Top instantiates it NUM_REGS times in a generate loop; top holds both FSMs and the decode.
// TESTING
//  (1) Reset release: read every reg -> RW=RST_VAL, W1C=0, RO=hw_ro_data, all rresp=OKAY, irq=0.
//  (2) RW reg 2: write 0xA5A5_A5A5, wstrb=4'b0101 over 0x0 ->
//      readback 0x00A5_00A5; wr_pulse[2] high one cycle.
//  (3) AW 3 cycles before W, then W before AW, and simultaneous ->
//      one B each, bvalid 1 cycle after last accept.
//  (4) W1C reg: hw_set=0x0F -> irq=1 next cycle; write 0x05 -> reads 0x0A;
//      same-cycle hw_set bit0 + clear bit0 -> bit0=1.
//  (5) Address NUM_REGS*STRB_WIDTH: write -> SLVERR, no wr_pulse, no reg change; read -> rdata=0, SLVERR.
//  (6) bready/rready held low 10 cycles -> bvalid/rvalid and data stable, awready/arready=0;
//      areset mid-hold -> all outputs return to reset values.

Source files
------------

// File: rtl/axi4_lite_regfile_gen_pkg.sv
// Shared types for the AXI4-Lite register file.
//   RESP_OKAY / RESP_SLVERR : AXI response codes.
//   reg_access_e            : per-register access type (RW, RO, W1C).
//   wr_state_e / rd_state_e : write and read channel FSM states.
//   access_of()             : maps the RO/W1C mask bits of one register to its access type.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } reg_access_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_GOT_AW,
    WR_GOT_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  // RO takes precedence if a register is (wrongly) flagged in both masks.
  function automatic reg_access_e access_of(input logic ro, input logic w1c);
    if (ro) begin
      return ACC_RO;
    end else if (w1c) begin
      return ACC_W1C;
    end
    return ACC_RW;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_gen_reg_cell.sv
// One register of the AXI4-Lite register file.
//   clk, rst     : clock, asynchronous active-high reset.
//   access       : access type (RW byte-merge, RO passthrough, W1C clear/set).
//   commit       : one-cycle write commit for this register.
//   wdata, wstrb : write data and byte strobes of the committing write.
//   hw_set       : per-bit set pulses (W1C only, applied every cycle).
//   hw_ro_data   : value presented for RO registers.
//   q            : current register value.
module axi4_lite_reg_cell
  import axi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  reg_access_e           access,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0] hw_set,
  input  logic [DATA_WIDTH-1:0] hw_ro_data,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic [DATA_WIDTH-1:0] rst_q;
  logic [DATA_WIDTH-1:0] store;

  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
      byte_mask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  always_comb begin
    wr_bits  = wdata & byte_mask;
    clr_bits = commit ? wr_bits : '0;
    // access is a tie-off, so this is a constant reset value per instance.
    rst_q    = (access == ACC_RW) ? RST_VAL : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store <= rst_q;
    end else begin
      case (access)
        ACC_RW: begin
          if (commit) begin
            store <= (store & ~byte_mask) | wr_bits;
          end
        end
        // Set is ORed in after the clear, so a same-cycle set wins.
        ACC_W1C: store <= (store & ~clr_bits) | hw_set;
        default: store <= store;
      endcase
    end
  end

  always_comb begin
    q = (access == ACC_RO) ? hw_ro_data : store;
  end

endmodule

// File: rtl/axi4_lite_regfile_gen.sv
// Parametrised AXI4-Lite register-file slave with NUM_REGS registers.
//   aclk, areset         : clock, asynchronous active-high reset.
//   aw*/w*/b*            : AXI4-Lite write address, data and response channels.
//   ar*/r*               : AXI4-Lite read address and data channels.
//   reg_q                : flat view of every register (slice i = reg i).
//   hw_ro_data           : values for RO registers.
//   hw_set               : per-bit set pulses for W1C registers.
//   wr_pulse             : one-cycle strobe per RW/W1C register after an OKAY write.
//   irq                  : registered OR of all W1C register bits.
module axi4_lite_regfile_gen
  import axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]   W1C_MASK   = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_data,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic                           irq
);

  localparam int unsigned IDX_BITS = $clog2(NUM_REGS);
  localparam int unsigned IDX_LSB  = $clog2(STRB_WIDTH);
  localparam int unsigned DEC_BITS = IDX_LSB + IDX_BITS;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> DEC_BITS) == '0;
  endfunction

  logic [DATA_WIDTH-1:0] q_arr [NUM_REGS];

  // ---------------- write channel ----------------
  wr_state_e             wr_state;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_ok;
  logic [IDX_BITS-1:0]   wr_idx;
  logic [NUM_REGS-1:0]   commit_vec;

  // The completing handshake commits on its own edge, so the half that arrived
  // earlier comes from the holding register and the other half from the bus.
  always_comb begin
    aw_fire = awvalid && awready;
    w_fire  = wvalid && wready;
    case (wr_state)
      WR_IDLE:   wr_commit = aw_fire && w_fire;
      WR_GOT_AW: wr_commit = w_fire;
      WR_GOT_W:  wr_commit = aw_fire;
      default:   wr_commit = 1'b0;
    endcase
    wr_addr    = (wr_state == WR_GOT_AW) ? aw_addr_q : awaddr;
    wr_data    = (wr_state == WR_GOT_W)  ? w_data_q  : wdata;
    wr_strb    = (wr_state == WR_GOT_W)  ? w_strb_q  : wstrb;
    wr_ok      = addr_in_range(wr_addr);
    wr_idx     = wr_addr[IDX_LSB +: IDX_BITS];
    commit_vec = '0;
    if (wr_commit && wr_ok) begin
      commit_vec[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state  <= WR_IDLE;
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_commit) begin
        bvalid   <= 1'b1;
        bresp    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        wr_pulse <= commit_vec & ~RO_MASK;
      end
      case (wr_state)
        WR_IDLE: begin
          if (aw_fire && w_fire) begin
            wr_state <= WR_RESP;
            awready  <= 1'b0;
            wready   <= 1'b0;
          end else if (aw_fire) begin
            wr_state  <= WR_GOT_AW;
            awready   <= 1'b0;
            aw_addr_q <= awaddr;
          end else if (w_fire) begin
            wr_state <= WR_GOT_W;
            wready   <= 1'b0;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
          end
        end
        WR_GOT_AW: begin
          if (w_fire) begin
            wr_state <= WR_RESP;
            wready   <= 1'b0;
          end
        end
        WR_GOT_W: begin
          if (aw_fire) begin
            wr_state <= WR_RESP;
            awready  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (bready) begin
            wr_state <= WR_IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        default: begin
          wr_state <= WR_IDLE;
          awready  <= 1'b1;
          wready   <= 1'b1;
          bvalid   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_e           rd_state;
  logic                ar_fire;
  logic                rd_ok;
  logic [IDX_BITS-1:0] rd_idx;

  always_comb begin
    ar_fire = arvalid && arready;
    rd_ok   = addr_in_range(araddr);
    rd_idx  = araddr[IDX_LSB +: IDX_BITS];
  end

  // Sampling q_arr at the AR edge returns the pre-write value on a same-cycle commit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_fire) begin
            rd_state <= RD_RESP;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata    <= rd_ok ? q_arr[rd_idx] : '0;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
          end
        end
        default: begin
          rd_state <= RD_IDLE;
          arready  <= 1'b1;
          rvalid   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- register array ----------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam reg_access_e ACC = access_of(RO_MASK[g], W1C_MASK[g]);

    axi4_lite_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VAL    (RST_VAL)
    ) u_cell (
      .clk        (aclk),
      .rst        (areset),
      .access     (ACC),
      .commit     (commit_vec[g]),
      .wdata      (wr_data),
      .wstrb      (wr_strb),
      .hw_set     (hw_set[g*DATA_WIDTH +: DATA_WIDTH]),
      .hw_ro_data (hw_ro_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .q          (q_arr[g])
    );

    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = q_arr[g];
  end

  // ---------------- interrupt ----------------
  logic w1c_any;

  always_comb begin
    w1c_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) begin
        w1c_any = w1c_any | (|q_arr[i]);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq <= 1'b0;
    end else begin
      irq <= w1c_any;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_gen.sv
// Self-checking bench for axi4_lite_regfile_gen: table of directed accesses
// followed by hand sequences for handshake ordering, W1C, same-cycle
// read/write, back-pressure and mid-transaction reset.
module tb_axi4_lite_regfile_gen;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam int          SW   = DW / 8;
  localparam logic [15:0] ROM  = 16'h0010;   // reg 4 read-only
  localparam logic [15:0] W1CM = 16'h0020;   // reg 5 write-1-to-clear
  localparam logic [31:0] RSTV = 32'hDEAD_BEEF;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [AW-1:0]  awaddr = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [SW-1:0]  wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b1;
  logic [AW-1:0]  araddr = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b1;
  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] hw_ro_data;
  logic [NR*DW-1:0] hw_set = '0;
  logic [NR-1:0]  wr_pulse;
  logic           irq;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4_lite_regfile_gen #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (ROM),
    .W1C_MASK   (W1CM),
    .RST_VAL    (RSTV)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .reg_q      (reg_q),
    .hw_ro_data (hw_ro_data),
    .hw_set     (hw_set),
    .wr_pulse   (wr_pulse),
    .irq        (irq)
  );

  function automatic logic [31:0] ro_val(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // aw_at / w_at: cycle (from task start) at which each valid is raised.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_at, input int w_at,
                          output logic [1:0] resp, output logic [15:0] pulse,
                          output logic [15:0] pulse_next, output bit timing_ok);
    bit aw_done, w_done, aw_now, w_now, early;
    int cyc;
    aw_done = 0; w_done = 0; early = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && (cyc >= aw_at);
      wvalid  = !w_done && (cyc >= w_at);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      if (bvalid) early = 1;
      @(posedge aclk); #1;
      aw_done = aw_done | aw_now;
      w_done  = w_done | w_now;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    timing_ok = aw_done && w_done && !early && (bvalid === 1'b1);
    resp  = bresp;
    pulse = wr_pulse;
    @(posedge aclk); #1;
    pulse_next = wr_pulse;
    if (bvalid !== 1'b0) timing_ok = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit ok);
    bit done, now;
    int cyc;
    done = 0; cyc = 0;
    araddr = addr;
    while (!done && cyc < 20) begin
      arvalid = 1'b1;
      now = arready;
      @(posedge aclk); #1;
      done = now;
      cyc++;
    end
    arvalid = 1'b0;
    ok   = done && (rvalid === 1'b1);
    data = rdata;
    resp = rresp;
    @(posedge aclk); #1;
    if (rvalid !== 1'b0) ok = 0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er,
                              input logic [15:0] ep, input string n);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s;
    v.exp_data = ed; v.exp_resp = er; v.exp_pulse = ep; v.name = n;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse, pulse_next;
    logic [31:0] data;
    bit          ok;

    for (int i = 0; i < NR; i++) hw_ro_data[i*DW +: DW] = ro_val(i);

    tbl.push_back(mk(1, 32'h08, 32'h0000_0000, 4'hF, 32'h0,         2'b00, 16'h0004, "clr_r2"));
    tbl.push_back(mk(1, 32'h08, 32'hA5A5_A5A5, 4'h5, 32'h0,         2'b00, 16'h0004, "part_r2"));
    tbl.push_back(mk(0, 32'h08, 32'h0,         4'h0, 32'h00A5_00A5, 2'b00, 16'h0,    "rd_r2"));
    tbl.push_back(mk(1, 32'h1C, 32'h1122_3344, 4'hF, 32'h0,         2'b00, 16'h0080, "full_r7"));
    tbl.push_back(mk(1, 32'h1C, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00, 16'h0080, "nostrb_r7"));
    tbl.push_back(mk(0, 32'h1C, 32'h0,         4'h0, 32'h1122_3344, 2'b00, 16'h0,    "rd_r7a"));
    tbl.push_back(mk(1, 32'h1C, 32'hAABB_CCDD, 4'hA, 32'h0,         2'b00, 16'h0080, "odd_r7"));
    tbl.push_back(mk(0, 32'h1C, 32'h0,         4'h0, 32'hAA22_CC44, 2'b00, 16'h0,    "rd_r7b"));
    tbl.push_back(mk(1, 32'h10, 32'h1234_5678, 4'hF, 32'h0,         2'b00, 16'h0,    "wr_ro"));
    tbl.push_back(mk(0, 32'h10, 32'h0,         4'h0, 32'hC0DE_0004, 2'b00, 16'h0,    "rd_ro"));
    tbl.push_back(mk(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10, 16'h0,    "wr_oor"));
    tbl.push_back(mk(0, 32'h40, 32'h0,         4'h0, 32'h0,         2'b10, 16'h0,    "rd_oor"));
    tbl.push_back(mk(0, 32'h00, 32'h0,         4'h0, RSTV,          2'b00, 16'h0,    "rd_r0"));
    tbl.push_back(mk(0, 32'h1000_0000, 32'h0,  4'h0, 32'h0,         2'b10, 16'h0,    "rd_hi"));
    tbl.push_back(mk(0, 32'h3C, 32'h0,         4'h0, RSTV,          2'b00, 16'h0,    "rd_r15"));

    // ---- reset ----
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ready", {awready, wready, arready}, 3'b111);
    check("rst_valid", {bvalid, rvalid, bresp, rresp}, 6'b0);
    check("rst_misc",  {rdata, wr_pulse, irq}, 49'h0);
    areset = 1'b0;
    @(posedge aclk); #1;

    for (int i = 0; i < NR; i++) begin
      logic [31:0] exp;
      exp = (i == 4) ? ro_val(4) : (i == 5) ? 32'h0 : RSTV;
      do_read(32'(i * 4), data, resp, ok);
      check($sformatf("rst_rd%0d", i), data, exp);
      check($sformatf("rst_rresp%0d", i), resp, 2'b00);
    end
    check("rst_irq", irq, 1'b0);

    // ---- directed table ----
    foreach (tbl[k]) begin
      if (tbl[k].is_wr) begin
        do_write(tbl[k].addr, tbl[k].data, tbl[k].strb, 0, 0, resp, pulse, pulse_next, ok);
        check({tbl[k].name, ".bresp"}, resp, tbl[k].exp_resp);
        check({tbl[k].name, ".pulse"}, pulse, tbl[k].exp_pulse);
        check({tbl[k].name, ".pulse_next"}, pulse_next, 16'h0);
        check({tbl[k].name, ".timing"}, ok, 1'b1);
      end else begin
        do_read(tbl[k].addr, data, resp, ok);
        check({tbl[k].name, ".rdata"}, data, tbl[k].exp_data);
        check({tbl[k].name, ".rresp"}, resp, tbl[k].exp_resp);
        check({tbl[k].name, ".handshake"}, ok, 1'b1);
      end
    end

    // ---- handshake orderings on reg 9 ----
    do_write(32'h24, 32'h9000_0001, 4'hF, 0, 3, resp, pulse, pulse_next, ok);
    check("aw_first.timing", ok, 1'b1);
    check("aw_first.pulse", pulse, 16'h0200);
    check("aw_first.reg", reg_q[9*DW +: DW], 32'h9000_0001);
    do_write(32'h24, 32'h9000_0002, 4'hF, 3, 0, resp, pulse, pulse_next, ok);
    check("w_first.timing", ok, 1'b1);
    check("w_first.pulse", pulse, 16'h0200);
    check("w_first.reg", reg_q[9*DW +: DW], 32'h9000_0002);
    do_write(32'h24, 32'h9000_0003, 4'hF, 0, 0, resp, pulse, pulse_next, ok);
    check("simul.timing", ok, 1'b1);
    check("simul.bresp", resp, 2'b00);
    do_read(32'h24, data, resp, ok);
    check("simul.rdata", data, 32'h9000_0003);

    // ---- same-cycle AR and commit to reg 9: read sees old value ----
    awaddr = 32'h24; wdata = 32'h7777_8888; wstrb = 4'hF; araddr = 32'h24;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_same.valids", {rvalid, bvalid}, 2'b11);
    check("rw_same.rdata", rdata, 32'h9000_0003);
    @(posedge aclk); #1;
    do_read(32'h24, data, resp, ok);
    check("rw_same.after", data, 32'h7777_8888);

    // ---- W1C reg 5 ----
    hw_set[5*DW +: DW] = 32'h0000_000F;
    @(posedge aclk); #1;
    hw_set[5*DW +: DW] = 32'h0;
    check("w1c.set_reg", reg_q[5*DW +: DW], 32'h0000_000F);
    @(posedge aclk); #1;
    check("w1c.irq_set", irq, 1'b1);
    do_read(32'h14, data, resp, ok);
    check("w1c.rd_set", data, 32'h0000_000F);
    do_write(32'h14, 32'h0000_0005, 4'hF, 0, 0, resp, pulse, pulse_next, ok);
    check("w1c.clr_pulse", pulse, 16'h0020);
    do_read(32'h14, data, resp, ok);
    check("w1c.rd_clr", data, 32'h0000_000A);
    // set and clear of bit 0 on the same edge
    hw_set[5*DW +: DW] = 32'h0000_0001;
    awaddr = 32'h14; wdata = 32'h0000_0001; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    hw_set[5*DW +: DW] = 32'h0;
    awvalid = 1'b0; wvalid = 1'b0;
    check("w1c.race_b", {bvalid, bresp}, 3'b100);
    @(posedge aclk); #1;
    do_read(32'h14, data, resp, ok);
    check("w1c.set_wins", data, 32'h0000_000B);
    check("w1c.irq_held", irq, 1'b1);

    // ---- back-pressure, then reset mid-hold ----
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h28; wdata = 32'h5555_AAAA; wstrb = 4'hF; araddr = 32'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d", c),
            {bvalid, bresp, rvalid, rresp, awready, wready, arready, rdata},
            {1'b1, 2'b00, 1'b1, 2'b00, 3'b000, RSTV});
      @(posedge aclk); #1;
    end
    check("hold.reg10", reg_q[10*DW +: DW], 32'h5555_AAAA);
    #2 areset = 1'b1;
    #1;
    check("mid_rst.ready", {awready, wready, arready}, 3'b111);
    check("mid_rst.valid", {bvalid, rvalid, bresp, rresp}, 6'b0);
    check("mid_rst.misc", {rdata, wr_pulse, irq}, 49'h0);
    check("mid_rst.reg10", reg_q[10*DW +: DW], RSTV);
    check("mid_rst.reg5", reg_q[5*DW +: DW], 32'h0);
    @(posedge aclk); #1;
    areset = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("post_rst.no_resp", {bvalid, rvalid}, 2'b00);
    do_read(32'h28, data, resp, ok);
    check("post_rst.rd10", data, RSTV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
